// File: rtl/aes_switch_sequencer.sv
// Switch-driven start/done sequencer for the AES encrypt/decrypt cores feeding the 7-segment display.
// Optional build macro AES_SEQ_AUTO_DECRYPT_EN chains encrypt completion straight into a decrypt run.
module aes_switch_sequencer #(
    parameter int unsigned  DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned  TIMEOUT_CYCLES  = 1024,
    parameter logic [127:0] PLAINTEXT       = 128'h00112233445566778899aabbccddeeff
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sw_encrypt,
    input  logic         sw_decrypt,
    output logic         enc_start,
    input  logic         enc_done,
    input  logic [127:0] enc_data,
    output logic         dec_start,
    output logic [127:0] dec_in,
    input  logic         dec_done,
    input  logic [127:0] dec_data,
    output logic [127:0] display_data,
    output logic [1:0]   display_mode,
    output logic         busy,
    output logic         error
);

    localparam int unsigned    DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] MODE_PLAIN  = 2'b00;
    localparam logic [1:0] MODE_CIPHER = 2'b01;
    localparam logic [1:0] MODE_REGEN  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ENC_RUN = 2'b01,
        DEC_RUN = 2'b10
    } state_t;

    state_t          state;
    logic [1:0]      enc_sync;
    logic [1:0]      dec_sync;
    logic            enc_level;
    logic            dec_level;
    logic [DB_W-1:0] enc_cnt;
    logic [DB_W-1:0] dec_cnt;
    logic            enc_edge;
    logic            dec_edge;
    logic            cipher_valid;
    logic [TO_W-1:0] run_cnt;
    logic            timeout_c;

    // Two-flop synchronisers for the asynchronous slide switches
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_sync <= 2'b00;
            dec_sync <= 2'b00;
        end else begin
            enc_sync <= {enc_sync[0], sw_encrypt};
            dec_sync <= {dec_sync[0], sw_decrypt};
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_level <= 1'b0;
            enc_cnt   <= '0;
            enc_edge  <= 1'b0;
        end else begin
            enc_edge <= 1'b0;
            if (enc_sync[1] == enc_level) begin
                enc_cnt <= '0;
            end else if (enc_cnt == DB_LAST) begin
                enc_level <= enc_sync[1];
                enc_cnt   <= '0;
                enc_edge  <= enc_sync[1];
            end else begin
                enc_cnt <= enc_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_level <= 1'b0;
            dec_cnt   <= '0;
            dec_edge  <= 1'b0;
        end else begin
            dec_edge <= 1'b0;
            if (dec_sync[1] == dec_level) begin
                dec_cnt <= '0;
            end else if (dec_cnt == DB_LAST) begin
                dec_level <= dec_sync[1];
                dec_cnt   <= '0;
                dec_edge  <= dec_sync[1];
            end else begin
                dec_cnt <= dec_cnt + DB_W'(1);
            end
        end
    end

    // run_cnt holds the number of RUN cycles already elapsed, so the abort lands after TIMEOUT_CYCLES
    assign timeout_c = (run_cnt >= TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            enc_start    <= 1'b0;
            dec_start    <= 1'b0;
            dec_in       <= '0;
            display_data <= PLAINTEXT;
            display_mode <= MODE_PLAIN;
            busy         <= 1'b0;
            error        <= 1'b0;
            cipher_valid <= 1'b0;
            run_cnt      <= '0;
        end else begin
            if (run_cnt != TO_MAX) begin
                run_cnt <= run_cnt + TO_W'(1);
            end
            case (state)
                IDLE: begin
                    if (enc_edge && dec_edge) begin
                        error <= 1'b1;
                    end else if (enc_edge) begin
                        state        <= ENC_RUN;
                        enc_start    <= 1'b1;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        display_mode <= MODE_PLAIN;
                        display_data <= PLAINTEXT;
                        run_cnt      <= '0;
                    end else if (dec_edge) begin
                        if (cipher_valid) begin
                            state     <= DEC_RUN;
                            dec_start <= 1'b1;
                            busy      <= 1'b1;
                            error     <= 1'b0;
                            run_cnt   <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ENC_RUN: begin
                    if (enc_done) begin
                        enc_start    <= 1'b0;
                        dec_in       <= enc_data;
                        display_data <= enc_data;
                        display_mode <= MODE_CIPHER;
                        cipher_valid <= 1'b1;
`ifdef AES_SEQ_AUTO_DECRYPT_EN
                        state        <= DEC_RUN;
                        dec_start    <= 1'b1;
                        run_cnt      <= '0;
`else
                        state        <= IDLE;
                        busy         <= 1'b0;
`endif
                    end else if (timeout_c) begin
                        enc_start <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DEC_RUN: begin
                    if (dec_done) begin
                        dec_start    <= 1'b0;
                        display_data <= dec_data;
                        display_mode <= MODE_REGEN;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (timeout_c) begin
                        dec_start <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_switch_sequencer.sv
// Randomised scoreboard bench for aes_switch_sequencer: a transaction-level model predicts every
// change of the observable output snapshot; a monitor compares each change it sees against the queue.
module tb_aes_switch_sequencer;

    localparam int unsigned  DB = 4;
    localparam int unsigned  TO = 16;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct packed {
        logic         busy;
        logic         error;
        logic         enc_start;
        logic         dec_start;
        logic [1:0]   mode;
        logic [127:0] data;
        logic [127:0] dec_in;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sw_encrypt = 1'b0;
    logic         sw_decrypt = 1'b0;
    logic         enc_start;
    logic         enc_done = 1'b0;
    logic [127:0] enc_data = '0;
    logic         dec_start;
    logic [127:0] dec_in;
    logic         dec_done = 1'b0;
    logic [127:0] dec_data = '0;
    logic [127:0] display_data;
    logic [1:0]   display_mode;
    logic         busy;
    logic         error;

    aes_switch_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .PLAINTEXT      (PT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_encrypt  (sw_encrypt),
        .sw_decrypt  (sw_decrypt),
        .enc_start   (enc_start),
        .enc_done    (enc_done),
        .enc_data    (enc_data),
        .dec_start   (dec_start),
        .dec_in      (dec_in),
        .dec_done    (dec_done),
        .dec_data    (dec_data),
        .display_data(display_data),
        .display_mode(display_mode),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t  exp_q[$];
    snap_t cur;
    logic  cipher_valid;
    bit    stim_done = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Queue an expected output change only if the model's visible state actually moves
    task automatic push(input snap_t s, input int c);
        exp_t e;
        if (s !== cur) begin
            e.s = s;
            e.cyc = c;
            exp_q.push_back(e);
            cur = s;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input bit is_enc, output int c0);
        c0 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_enc ? enc_start : dec_start) begin
                c0 = cyc;
                break;
            end
        end
    endtask

    // Finish a run either by a done pulse d cycles after start, or by letting it time out
    task automatic run_phase(input bit is_enc, input int c0, input bit tmo, input int d,
                             input logic [127:0] data, output int c_end);
        snap_t s;
        s = cur;
        c_end = -1;
        s.busy = 1'b0;
        s.enc_start = 1'b0;
        s.dec_start = 1'b0;
        if (tmo) begin
            s.error = 1'b1;
            push(s, c0 + TO);
            while (cyc < c0 + TO + 2) @(negedge clk);
        end else begin
            while (cyc < c0 + d) @(negedge clk);
            if (is_enc) begin
                s.mode = 2'b01;
                s.data = data;
                s.dec_in = data;
                cipher_valid = 1'b1;
`ifdef AES_SEQ_AUTO_DECRYPT_EN
                s.busy = 1'b1;
                s.dec_start = 1'b1;
`endif
                enc_data = data;
                enc_done = 1'b1;
            end else begin
                s.mode = 2'b10;
                s.data = data;
                dec_data = data;
                dec_done = 1'b1;
            end
            push(s, cyc + 1);
            @(negedge clk);
            enc_done = 1'b0;
            dec_done = 1'b0;
            c_end = cyc;
        end
    endtask

    task automatic do_encrypt(input bit glitch, input bit tmo, input int d, input logic [127:0] c);
        snap_t s;
        int c0;
        int ce;
        int ce2;
        s = cur;
        s.busy = 1'b1;
        s.enc_start = 1'b1;
        s.error = 1'b0;
        s.mode = 2'b00;
        s.data = PT;
        push(s, -1);
        if (glitch) begin
            sw_encrypt = 1'b1;
            @(negedge clk);
            sw_encrypt = 1'b0;
            @(negedge clk);
        end
        sw_encrypt = 1'b1;
        wait_start(1'b1, c0);
        if (c0 >= 0) begin
            run_phase(1'b1, c0, tmo, d, c, ce);
`ifdef AES_SEQ_AUTO_DECRYPT_EN
            if (ce >= 0)
                run_phase(1'b0, ce, ($urandom_range(0, 3) == 0), $urandom_range(0, 12), rand128(), ce2);
`endif
        end
        sw_encrypt = 1'b0;
        idle(14);
    endtask

    task automatic do_reject(input bit both);
        snap_t s;
        s = cur;
        s.error = 1'b1;
        push(s, -1);
        sw_decrypt = 1'b1;
        if (both) sw_encrypt = 1'b1;
        idle(14);
        sw_decrypt = 1'b0;
        sw_encrypt = 1'b0;
        idle(14);
    endtask

    task automatic do_decrypt(input bit tmo, input int d, input logic [127:0] p);
        snap_t s;
        int c0;
        int ce;
        if (!cipher_valid) begin
            do_reject(1'b0);
        end else begin
            s = cur;
            s.busy = 1'b1;
            s.dec_start = 1'b1;
            s.error = 1'b0;
            push(s, -1);
            sw_decrypt = 1'b1;
            wait_start(1'b0, c0);
            if (c0 >= 0) run_phase(1'b0, c0, tmo, d, p, ce);
            sw_decrypt = 1'b0;
            idle(14);
        end
    endtask

    task automatic apply_reset();
        snap_t s;
        s = '0;
        s.data = PT;
        push(s, -1);
        cipher_valid = 1'b0;
        reset = 1'b1;
        sw_encrypt = 1'b0;
        sw_decrypt = 1'b0;
        enc_done = 1'b0;
        dec_done = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(4);
    endtask

    task automatic midrun_reset();
        snap_t s;
        int c0;
        s = cur;
        s.busy = 1'b1;
        s.enc_start = 1'b1;
        s.error = 1'b0;
        s.mode = 2'b00;
        s.data = PT;
        push(s, -1);
        sw_encrypt = 1'b1;
        wait_start(1'b1, c0);
        if (c0 >= 0) idle($urandom_range(0, 5));
        apply_reset();
    endtask

    // done pulses while idle must leave every output untouched
    task automatic idle_noise();
        enc_data = rand128();
        dec_data = rand128();
        enc_done = 1'b1;
        dec_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
        dec_done = 1'b0;
        idle(3);
    endtask

    // Stimulus / reference model
    initial begin
        exp_t e0;
        int op;
        cur = '0;
        cur.data = PT;
        cipher_valid = 1'b0;
        e0.s = cur;
        e0.cyc = -1;
        exp_q.push_back(e0);
        idle(3);
        reset = 1'b0;
        idle(4);

        do_encrypt(1'b1, 1'b0, 10, CT);
        do_decrypt(1'b0, 10, PT);
        apply_reset();
        do_decrypt(1'b0, 10, PT);
        do_encrypt(1'b0, 1'b0, $urandom_range(0, 12), rand128());
        do_encrypt(1'b0, 1'b1, 0, '0);
        do_reject(1'b1);
        idle_noise();
        midrun_reset();

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            if (op < 4)       do_encrypt($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                                         $urandom_range(0, 12), rand128());
            else if (op < 7)  do_decrypt($urandom_range(0, 4) == 0, $urandom_range(0, 12), rand128());
            else if (op == 7) do_reject(1'b1);
            else if (op == 8) idle_noise();
            else              midrun_reset();
        end
        idle(10);
        stim_done = 1'b1;
    end

    function automatic snap_t snap_now();
        return {busy, error, enc_start, dec_start, display_mode, display_data, dec_in};
    endfunction

    task automatic check_event(input snap_t s);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %h at cycle %0d, no change was predicted", s, cyc);
        end else begin
            e = exp_q.pop_front();
            if (s !== e.s || (e.cyc >= 0 && cyc != e.cyc)) begin
                miscompares++;
                $display("FAIL event_%0d: got %h at cycle %0d, required %h at cycle %0d",
                         vectors, s, cyc, e.s, e.cyc);
            end
        end
    endtask

    // Monitor: every change of the output snapshot must match the next predicted change
    initial begin
        snap_t prev;
        snap_t s;
        exp_t  e;
        idle(3);
        s = snap_now();
        check_event(s);
        prev = s;
        while (!stim_done) begin
            @(negedge clk);
            s = snap_now();
            if (s !== prev) begin
                check_event(s);
                prev = s;
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got no change, required %h at cycle %0d", e.s, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
